// File: rtl/rsa_result_framer.sv
// Frames an N-bit exponentiator result for a byte UART: SYNC, LEN, data bytes
// LSB first, then CHK (XOR of LEN and data). One result may wait in a pending slot.
module rsa_result_framer #(
  parameter int unsigned N    = 64,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_bytes,
  input  logic         is_transmitting,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned NB       = N / 8;
  localparam int unsigned LAST     = NB + 2;
  localparam int unsigned IW       = $clog2(LAST + 1);
  localparam logic [IW-1:0] IDX_LEN  = IW'(1);
  localparam logic [IW-1:0] LAST_IDX = IW'(LAST);
  localparam logic [7:0]    LEN      = 8'(NB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t        r_state;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_pend_data;
  logic          r_pend_valid;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_chk;
  logic [7:0]    r_tx_byte;
  logic          r_tx_valid;
  logic          r_overrun;

  logic          w_frame_done;
  logic          w_boundary;
  logic          w_start;
  logic          w_is_data;
  logic [N-1:0]  w_start_word;
  logic [7:0]    w_cur_byte;

  // A frame boundary is either IDLE or the final WAIT_LO exit; a word offered
  // there (from the slot first, else from rx) starts the next frame directly.
  always_comb begin
    w_frame_done = (r_state == WAIT_LO) && !is_transmitting && (r_idx == LAST_IDX);
    w_boundary   = (r_state == IDLE) || w_frame_done;
    w_start      = w_boundary && (r_pend_valid || rx_valid);
    w_start_word = r_pend_valid ? r_pend_data : rx_bytes;
    w_is_data    = (r_idx > IDX_LEN) && (r_idx < LAST_IDX);
    if (r_idx == '0)
      w_cur_byte = SYNC;
    else if (r_idx == IDX_LEN)
      w_cur_byte = LEN;
    else if (r_idx == LAST_IDX)
      w_cur_byte = r_chk;
    else
      w_cur_byte = r_shift[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_chk        <= '0;
      r_tx_byte    <= '0;
      r_tx_valid   <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      r_overrun  <= 1'b0;

      // At a boundary a full slot is consumed and may be refilled in the same cycle.
      if (w_boundary) begin
        if (r_pend_valid) begin
          r_pend_valid <= rx_valid;
          if (rx_valid)
            r_pend_data <= rx_bytes;
        end
      end else if (rx_valid) begin
        if (r_pend_valid) begin
          r_overrun <= 1'b1;
        end else begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= rx_bytes;
        end
      end

      if (w_start) begin
        r_shift <= w_start_word;
        r_idx   <= '0;
        r_chk   <= LEN;
        r_state <= ISSUE;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          ISSUE: begin
            if (!is_transmitting) begin
              r_tx_byte  <= w_cur_byte;
              r_tx_valid <= 1'b1;
              if (w_is_data) begin
                r_shift <= r_shift >> 8;
                r_chk   <= r_chk ^ r_shift[7:0];
              end
              r_state <= WAIT_HI;
            end
          end
          WAIT_HI: begin
            if (is_transmitting)
              r_state <= WAIT_LO;
          end
          WAIT_LO: begin
            if (!is_transmitting) begin
              if (r_idx == LAST_IDX) begin
                r_state <= IDLE;
              end else begin
                r_idx   <= r_idx + IW'(1);
                r_state <= ISSUE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign tx_byte  = r_tx_byte;
  assign tx_valid = r_tx_valid;
  assign overrun  = r_overrun;
  assign busy     = (r_state != IDLE) || r_pend_valid;

endmodule

// File: tb/tb_rsa_result_framer.sv
// Directed bench for rsa_result_framer: frame-level byte model, UART busy model,
// and literal frame contents for the nominal, back-to-back and overrun cases.
module tb_rsa_result_framer;

  localparam int unsigned NB = 8;
  localparam int unsigned UD = 3;
  localparam int unsigned LIM = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [63:0] rx_bytes = '0;
  logic        is_transmitting;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic        overrun;

  logic        hold = 1'b0;
  int unsigned ucnt = 0;
  logic        u_seen;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_strobe = 0;
  int unsigned n_overrun = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs[$];
  logic [7:0]  last_byte = '0;
  logic        rst_seen = 1'b0;
  logic        armed = 1'b0;
  logic        need_busy = 1'b0;
  logic        prev_is_tx = 1'b0;
  logic        busy_hold = 1'b0;

  logic [7:0] NOM [11] = '{8'hA5, 8'h08, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01, 8'h08};

  rsa_result_framer #(.N(64), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_bytes(rx_bytes),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // UART: busy for UD cycles starting the cycle after each strobe, or forced by hold.
  assign is_transmitting = hold || (ucnt != 0);
  always @(posedge clk) begin
    u_seen = tx_valid;
    rst_seen = rst;
    #1;
    if (u_seen === 1'b1) ucnt = UD;
    else if (ucnt != 0) ucnt = ucnt - 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void push_frame(input logic [63:0] w);
    logic [7:0] c;
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(NB));
    c = 8'(NB);
    for (int i = 0; i < NB; i++) begin
      b = w[8*i +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endfunction

  always @(negedge clk) begin
    if (is_transmitting) need_busy = 1'b0;
    if (rst_seen) begin
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      exp_q.delete();
      last_byte = '0;
      need_busy = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (tx_valid === 1'b1) begin
        n_strobe++;
        obs.push_back(tx_byte);
        chk("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tx_byte", tx_byte, exp_q.pop_front());
        chk("strobe_after_uart_cycle", need_busy, 0);
        chk("strobe_uart_idle", prev_is_tx, 0);
        last_byte = tx_byte;
        need_busy = 1'b1;
      end else begin
        chk("tx_byte_hold", tx_byte, last_byte);
      end
      if (overrun === 1'b1) n_overrun++;
      if (busy_hold) chk("busy_held", busy, 1);
    end
    prev_is_tx = is_transmitting;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input bit accept);
    rx_valid = 1'b1;
    rx_bytes = w;
    if (accept) push_frame(w);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int unsigned target);
    int unsigned k = 0;
    while (n_strobe < target && k < LIM) begin
      tick();
      k++;
    end
    chk("strobe_wait_in_time", n_strobe >= target, 1);
  endtask

  task automatic wait_idle();
    int unsigned k = 0;
    while ((busy !== 1'b0 || is_transmitting || exp_q.size() != 0) && k < LIM) begin
      tick();
      k++;
    end
    chk("idle_in_time", k < LIM, 1);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int unsigned base;
    int unsigned ov0;
    logic [63:0] w;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Nominal frame and two-cycle latency
    obs.delete();
    rx_valid = 1'b1;
    rx_bytes = 64'h0123456789ABCDEF;
    push_frame(64'h0123456789ABCDEF);
    tick();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("lat_t1_tx_valid", tx_valid, 0);
    chk("lat_t1_busy", busy, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("lat_t2_tx_valid", tx_valid, 1);
    chk("lat_t2_tx_byte", tx_byte, 8'hA5);
    wait_idle();
    chk("nom_count", obs.size(), 11);
    for (int i = 0; i < 11 && i < obs.size(); i++)
      chk($sformatf("nom_byte%0d", i), obs[i], NOM[i]);

    // Pending word and back-to-back frames
    obs.delete();
    ov0 = n_overrun;
    base = n_strobe;
    send(64'h0, 1);
    busy_hold = 1'b1;
    repeat (8) tick();
    send(64'hFFFFFFFFFFFFFFFF, 1);
    wait_strobes(base + 22);
    busy_hold = 1'b0;
    wait_idle();
    chk("b2b_count", obs.size(), 22);
    if (obs.size() == 22) begin
      chk("b2b_f1_sync", obs[0], 8'hA5);
      chk("b2b_f1_data", obs[5], 8'h00);
      chk("b2b_f1_chk", obs[10], 8'h08);
      chk("b2b_f2_sync", obs[11], 8'hA5);
      chk("b2b_f2_len", obs[12], 8'h08);
      chk("b2b_f2_data", obs[16], 8'hFF);
      chk("b2b_f2_chk", obs[21], 8'h08);
    end
    chk("b2b_no_overrun", n_overrun - ov0, 0);

    // Overrun: pending slot filled, two further words dropped
    obs.delete();
    ov0 = n_overrun;
    send(64'h1122334455667788, 1);
    repeat (6) tick();
    send(64'h99AABBCCDDEEFF00, 1);
    repeat (3) tick();
    send(64'hDEADBEEFDEADBEEF, 0);
    repeat (3) tick();
    send(64'hCAFEF00DCAFEF00D, 0);
    wait_idle();
    chk("ovr_pulses", n_overrun - ov0, 2);
    chk("ovr_two_frames", obs.size(), 22);
    if (obs.size() == 22) chk("ovr_f2_chk", obs[21], 8'h08 ^ 8'h99 ^ 8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD ^ 8'hEE ^ 8'hFF ^ 8'h00);

    // New word offered at and around the frame-end cycle
    ov0 = n_overrun;
    for (int off = 0; off < 6; off++) begin
      base = n_strobe;
      w = 64'h0F1E2D3C4B5A6978 ^ {32'(off), 32'(off)};
      send(w, 1);
      wait_strobes(base + 11);
      repeat (off) tick();
      send(~w, 1);
      wait_idle();
      chk("edge_two_frames", n_strobe - base, 22);
    end
    chk("edge_no_overrun", n_overrun - ov0, 0);

    // Reset after the 4th strobe, with rx_valid during reset
    base = n_strobe;
    send(64'h0102030405060708, 1);
    wait_strobes(base + 4);
    rst = 1'b1;
    rx_valid = 1'b1;
    rx_bytes = 64'h5555AAAA5555AAAA;
    tick();
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (25) tick();
    chk("rst_no_resume", n_strobe, base + 4);
    chk("rst_idle_busy", busy, 0);
    obs.delete();
    send(64'h8877665544332211, 1);
    wait_idle();
    chk("rst_next_frame_len", obs.size(), 11);
    if (obs.size() == 11) chk("rst_next_first_data", obs[2], 8'h11);

    // UART busy when the result arrives
    obs.delete();
    hold = 1'b1;
    tick();
    base = n_strobe;
    send(64'h0123456789ABCDEF, 1);
    repeat (10) tick();
    chk("hold_no_strobe", n_strobe, base);
    hold = 1'b0;
    wait_idle();
    chk("hold_count", obs.size(), 11);
    for (int i = 0; i < 11 && i < obs.size(); i++)
      chk($sformatf("hold_byte%0d", i), obs[i], NOM[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
